// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment digit scan controller.
package digit_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } scan_state_t;

   localparam int NUM_DIGITS = 4;
   localparam int PWM_LEVELS = 8;

   localparam logic [7:0] SEG_OFF   = 8'h00;
   localparam logic [3:0] SEGCS_OFF = 4'hF;

   // Active-low one-hot select for the given digit.
   function automatic logic [3:0] digit_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Pattern-update handshake between the bus register block and the scan controller.
interface digit_scan_ctrl_if;
   import digit_scan_ctrl_pkg::*;

   logic [NUM_DIGITS*8-1:0] segIn;
   logic [NUM_DIGITS-1:0]   digitEn;
   logic                    updReq;
   logic                    updAck;

   modport master (output segIn, output digitEn, output updReq, input updAck);
   modport slave  (input segIn, input digitEn, input updReq, output updAck);

endinterface

// File: rtl/digit_scan_ctrl_pwm_gate.sv
// Brightness gate: a digit is lit for the first (bright+1) chunks of its on-window.
module digit_scan_ctrl_pwm_gate #(
   parameter int CNT_W = 16,
   parameter int CHUNK = 6000
) (
   input  logic [CNT_W-1:0] i_onIdx,
   input  logic [2:0]       i_bright,
   output logic             o_lit
);

   localparam int LIM_W = CNT_W + 4;

   logic [LIM_W-1:0] w_limit;

   assign w_limit = LIM_W'(CHUNK) * LIM_W'({1'b0, i_bright} + 4'd1);
   assign o_lit   = LIM_W'(i_onIdx) < w_limit;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Digit scan scheduler: slot/blank sequencing, PWM brightness and frame-synchronous
// shadow-register loading for a 4-digit multiplexed seven-segment display.
module digit_scan_ctrl
   import digit_scan_ctrl_pkg::*;
#(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 2000,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [2:0]              bright,
   digit_scan_ctrl_if.slave        upd,
   output logic                    frameTick,
   output logic [7:0]              SEG,
   output logic [3:0]              SEGCS
);

   localparam int                CHUNK     = (SLOT_CYCLES - BLANK_CYCLES) / PWM_LEVELS;
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam scan_state_t       SLOT_ST   = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

   scan_state_t                   r_state;
   logic [CNT_W-1:0]              r_slotCnt;
   logic [1:0]                    r_digitIdx;
   logic [NUM_DIGITS-1:0][7:0]    r_shadowSeg;
   logic [NUM_DIGITS-1:0]         r_shadowEn;
   logic                          r_armed;
   logic                          r_updAck;
   logic                          r_frameTick;
   logic [7:0]                    r_seg;
   logic [3:0]                    r_segcs;

   logic                          w_frameEnd;
   logic                          w_load;
   logic [CNT_W-1:0]              w_onIdx;
   logic                          w_pwmLit;
   logic                          w_lit;

   assign w_frameEnd = (r_state != ST_IDLE) && (r_digitIdx == 2'd3) && (r_slotCnt == LAST_CNT);
   assign w_load     = upd.updReq && r_armed && (w_frameEnd || (r_state == ST_IDLE));
   assign w_onIdx    = r_slotCnt - CNT_W'(BLANK_CYCLES);

   digit_scan_ctrl_pwm_gate #(
      .CNT_W (CNT_W),
      .CHUNK (CHUNK)
   ) u_pwm_gate (
      .i_onIdx  (w_onIdx),
      .i_bright (bright),
      .o_lit    (w_pwmLit)
   );

   // Gating with enable makes the display go dark on the cycle right after enable drops.
   assign w_lit = enable && (r_state == ST_ON) && w_pwmLit && r_shadowEn[r_digitIdx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_slotCnt   <= '0;
         r_digitIdx  <= '0;
         r_shadowSeg <= '0;
         r_shadowEn  <= '0;
         r_armed     <= 1'b1;
         r_updAck    <= 1'b0;
         r_frameTick <= 1'b0;
         r_seg       <= SEG_OFF;
         r_segcs     <= SEGCS_OFF;
      end else begin
         r_seg       <= w_lit ? r_shadowSeg[r_digitIdx] : SEG_OFF;
         r_segcs     <= w_lit ? digit_sel(r_digitIdx) : SEGCS_OFF;
         r_frameTick <= w_frameEnd;
         r_updAck    <= w_load;

         if (w_load) begin
            r_shadowSeg <= upd.segIn;
            r_shadowEn  <= upd.digitEn;
         end
         // One ack per request: re-arm only once the requester drops updReq.
         if (!upd.updReq) begin
            r_armed <= 1'b1;
         end else if (w_load) begin
            r_armed <= 1'b0;
         end

         if (!enable) begin
            r_state    <= ST_IDLE;
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state    <= SLOT_ST;
                  r_slotCnt  <= '0;
                  r_digitIdx <= '0;
               end
               ST_BLANK, ST_ON: begin
                  if (r_slotCnt == LAST_CNT) begin
                     r_state    <= SLOT_ST;
                     r_slotCnt  <= '0;
                     r_digitIdx <= r_digitIdx + 2'd1;
                  end else begin
                     r_slotCnt <= r_slotCnt + 1'b1;
                     if ((r_state == ST_BLANK) && (r_slotCnt == BLANK_END)) begin
                        r_state <= ST_ON;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign upd.updAck = r_updAck;
   assign frameTick  = r_frameTick;
   assign SEG        = r_seg;
   assign SEGCS      = r_segcs;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized bench for digit_scan_ctrl against a frame-position reference model.
module tb_digit_scan_ctrl;

   localparam int SLOT  = 20;
   localparam int BLANK = 4;
   localparam int CHUNK = (SLOT - BLANK) / 8;
   localparam int FRAME = 4 * SLOT;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] bright;
   logic       frameTick;
   logic [7:0] SEG;
   logic [3:0] SEGCS;

   digit_scan_ctrl_if u_if ();

   digit_scan_ctrl #(
      .SLOT_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK),
      .CNT_W        (16)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .bright    (bright),
      .upd       (u_if.slave),
      .frameTick (frameTick),
      .SEG       (SEG),
      .SEGCS     (SEGCS)
   );

   always #5 clk = ~clk;

   // Reference state: position within the 80-cycle frame (-1 when not scanning).
   int         m_ph;
   logic [7:0] m_sh [4];
   logic [3:0] m_en;
   bit         m_armed;

   logic [7:0] e_seg;
   logic [3:0] e_cs;
   logic       e_ack;
   logic       e_tick;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int  slot;
      int  pos;
      bit  fend;
      bit  load;
      bit  lit;
      if (rst) begin
         m_ph    = -1;
         m_armed = 1'b1;
         m_en    = 4'h0;
         for (int k = 0; k < 4; k++) m_sh[k] = 8'h00;
         e_seg  = 8'h00;
         e_cs   = 4'hF;
         e_ack  = 1'b0;
         e_tick = 1'b0;
      end else begin
         fend = (m_ph == FRAME - 1);
         load = u_if.updReq && m_armed && (fend || m_ph < 0);
         lit  = 1'b0;
         slot = 0;
         if (m_ph >= 0) begin
            slot = m_ph / SLOT;
            pos  = m_ph % SLOT;
            lit  = enable && (pos >= BLANK) && ((pos - BLANK) < CHUNK * (int'(bright) + 1))
                   && m_en[slot];
         end
         e_seg = lit ? m_sh[slot] : 8'h00;
         e_cs  = 4'hF;
         if (lit) e_cs[slot] = 1'b0;
         e_ack  = load;
         e_tick = fend;
         if (load) begin
            for (int k = 0; k < 4; k++) m_sh[k] = u_if.segIn[8*k +: 8];
            m_en = u_if.digitEn;
         end
         if (!u_if.updReq) m_armed = 1'b1;
         else if (load)    m_armed = 1'b0;
         if (!enable)       m_ph = -1;
         else if (m_ph < 0) m_ph = 0;
         else               m_ph = (m_ph + 1) % FRAME;
      end
   endtask

   task automatic tick_cycle();
      model_step();
      @(posedge clk);
      #1;
      check("SEG", 32'(SEG), 32'(e_seg));
      check("SEGCS", 32'(SEGCS), 32'(e_cs));
      check("updAck", 32'(u_if.updAck), 32'(e_ack));
      check("frameTick", 32'(frameTick), 32'(e_tick));
   endtask

   task automatic run(input int n);
      repeat (n) tick_cycle();
   endtask

   task automatic run_to_phase(input int ph);
      for (int i = 0; i < 2 * FRAME && m_ph != ph; i++) tick_cycle();
   endtask

   initial begin
      rst            = 1'b1;
      enable         = 1'b0;
      bright         = 3'd7;
      u_if.segIn     = '0;
      u_if.digitEn   = '0;
      u_if.updReq    = 1'b0;
      run(3);

      // IDLE load then full-brightness scan
      rst          = 1'b0;
      u_if.segIn   = 32'h3F06_5B4F;
      u_if.digitEn = 4'hF;
      u_if.updReq  = 1'b1;
      run(3);
      u_if.updReq = 1'b0;
      enable      = 1'b1;
      run(2 * FRAME + 5);

      // brightness levels
      bright = 3'd0;
      run(FRAME);
      bright = 3'd3;
      run(FRAME);
      bright = 3'd7;

      // held request mid-frame, then re-arm
      run_to_phase(30);
      u_if.segIn  = 32'h1122_3344;
      u_if.updReq = 1'b1;
      run(2 * FRAME);
      u_if.updReq = 1'b0;
      run(1);
      u_if.segIn  = 32'h5566_7788;
      u_if.updReq = 1'b1;
      run(FRAME + 2);
      u_if.updReq = 1'b0;

      // digits 1 and 3 disabled
      u_if.digitEn = 4'b0101;
      u_if.segIn   = $urandom;
      u_if.updReq  = 1'b1;
      run(FRAME);
      u_if.updReq = 1'b0;
      run(FRAME);

      // enable drop during digit 2 on-window
      run_to_phase(2 * SLOT + 10);
      enable = 1'b0;
      run(5);
      enable = 1'b1;
      run(FRAME);

      // reset mid on-window with a pending request
      run_to_phase(BLANK + 3);
      rst         = 1'b1;
      u_if.updReq = 1'b1;
      run(3);
      u_if.updReq = 1'b0;
      rst         = 1'b0;
      run(FRAME);

      // randomized traffic
      u_if.digitEn = 4'hF;
      u_if.updReq  = 1'b1;
      run(FRAME + 2);
      for (int i = 0; i < 3000; i++) begin
         u_if.segIn = $urandom;
         if ($urandom_range(0, 99) < 4) u_if.updReq = ~u_if.updReq;
         if ($urandom_range(0, 99) < 5) u_if.digitEn = 4'($urandom);
         if ($urandom_range(0, 99) < 2) bright = 3'($urandom);
         if (enable) begin
            if ($urandom_range(0, 999) < 3) enable = 1'b0;
         end else if ($urandom_range(0, 99) < 10) begin
            enable = 1'b1;
         end
         rst = ($urandom_range(0, 999) < 2);
         tick_cycle();
      end
      rst = 1'b0;
      run(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
